// File: rtl/des_dec_key_scheduler_if.sv
// rtl/des_dec_key_scheduler_if.sv - handshake bundle between the DES decrypt key scheduler and its user
//
// Groups the key-load request, the round-key stream and the status flags.
//   master : drives start_strobe_din, key_din, round_key_ready_din; observes the rest
//   slave  : the key scheduler itself
interface des_dec_key_scheduler_if;
  logic        start_strobe_din;
  logic [0:63] key_din;
  logic        round_key_ready_din;
  logic [0:47] round_key_dout;
  logic        round_key_valid_dout;
  logic [3:0]  round_number_dout;
  logic        busy_dout;
  logic        done_strobe_dout;

  modport master (
    output start_strobe_din, key_din, round_key_ready_din,
    input  round_key_dout, round_key_valid_dout, round_number_dout, busy_dout, done_strobe_dout
  );

  modport slave (
    input  start_strobe_din, key_din, round_key_ready_din,
    output round_key_dout, round_key_valid_dout, round_number_dout, busy_dout, done_strobe_dout
  );
endinterface

// File: rtl/des_dec_key_scheduler.sv
// rtl/des_dec_key_scheduler.sv - DES decryption round-key generator, K16 down to K1
//
// Loads a 64-bit key, then streams the 16 subkeys in reverse order, one per
// valid/ready handshake, by rotating the C/D halves right.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   kif   : slave side of des_dec_key_scheduler_if
//     start_strobe_din / key_din     : key load request (ignored while busy)
//     round_key_ready_din            : consumer accepts the current subkey
//     round_key_dout / round_number_dout / round_key_valid_dout : subkey stream
//     busy_dout / done_strobe_dout   : sequence in progress / one-cycle completion pulse
module des_dec_key_scheduler (
  input  logic                          clk,
  input  logic                          reset,
  des_dec_key_scheduler_if.slave        kif
);

  typedef enum logic {IDLE, EMIT} state_t;

  // FIPS 46-3 PC-1 and PC-2, 1-based source bit positions.
  localparam logic [6:0] pc1_tab [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam logic [6:0] pc2_tab [0:47] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  state_t      state;
  logic [0:27] c_reg;
  logic [0:27] d_reg;
  logic [3:0]  counter;
  logic        done;

  logic [0:55] pc1_out;
  logic [0:55] cd;
  logic [0:47] pc2_out;
  logic        single_shift;
  logic        unused_parity;

  always_comb begin
    pc1_out = '0;
    for (int i = 0; i < 56; i++) begin
      pc1_out[i] = kif.key_din[6'(pc1_tab[i] - 7'd1)];
    end
  end

  assign cd = {c_reg, d_reg};

  always_comb begin
    pc2_out = '0;
    for (int i = 0; i < 48; i++) begin
      pc2_out[i] = cd[6'(pc2_tab[i] - 7'd1)];
    end
  end

  // Parity bits never reach PC-1.
  assign unused_parity = ^{kif.key_din[7], kif.key_din[15], kif.key_din[23], kif.key_din[31],
                           kif.key_din[39], kif.key_din[47], kif.key_din[55], kif.key_din[63]};

  // Undo the encryption shift of round counter+1; rounds 1, 2, 9, 16 shift by one.
  assign single_shift = (counter == 4'd15) || (counter == 4'd8) || (counter == 4'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      c_reg   <= '0;
      d_reg   <= '0;
      counter <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // C16,D16 equal C0,D0 (total shift 28), so K16 comes straight from PC-1.
          if (kif.start_strobe_din) begin
            c_reg   <= pc1_out[0:27];
            d_reg   <= pc1_out[28:55];
            counter <= 4'd15;
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (kif.round_key_ready_din) begin
            if (counter == 4'd0) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              if (single_shift) begin
                c_reg <= {c_reg[27], c_reg[0:26]};
                d_reg <= {d_reg[27], d_reg[0:26]};
              end else begin
                c_reg <= {c_reg[26:27], c_reg[0:25]};
                d_reg <= {d_reg[26:27], d_reg[0:25]};
              end
              counter <= counter - 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign kif.round_key_dout       = pc2_out;
  assign kif.round_key_valid_dout = (state == EMIT);
  assign kif.busy_dout            = (state == EMIT);
  assign kif.round_number_dout    = counter;
  assign kif.done_strobe_dout     = done;

endmodule

// File: tb/tb_des_dec_key_scheduler.sv
// tb/tb_des_dec_key_scheduler.sv - self-checking bench for des_dec_key_scheduler
module tb_des_dec_key_scheduler;

  typedef struct {
    logic [3:0]  rnd;
    logic [47:0] key;
  } vec_t;

  localparam logic [63:0] main_key   = 64'h133457799BBCDFF1;
  localparam logic [63:0] parity_key = 64'h123456789ABCDEF0;
  localparam logic [63:0] other_key  = 64'hFEDCBA9876543210;

  logic clk;
  logic reset;
  des_dec_key_scheduler_if kif ();

  des_dec_key_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .kif   (kif)
  );

  int   total = 0;
  int   bad   = 0;
  vec_t tbl [16];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [63:0] k);
    kif.start_strobe_din = 1'b1;
    kif.key_din          = k;
    step();
    kif.start_strobe_din = 1'b0;
  endtask

  // Expects to be called in the first EMIT cycle; returns in the done-pulse cycle.
  task automatic emit_all(input bit inject);
    for (int i = 0; i < 16; i++) begin
      kif.round_key_ready_din = 1'b1;
      if (inject && (tbl[i].rnd == 4'd8 || tbl[i].rnd == 4'd0)) begin
        kif.start_strobe_din = 1'b1;
        kif.key_din          = other_key;
      end
      @(negedge clk);
      chk("emit", {kif.round_key_valid_dout, kif.busy_dout, kif.round_number_dout, kif.round_key_dout},
          {1'b1, 1'b1, tbl[i].rnd, tbl[i].key});
      step();
      kif.start_strobe_din = 1'b0;
    end
    @(negedge clk);
    chk("done_pulse", {kif.round_key_valid_dout, kif.busy_dout, kif.done_strobe_dout}, 3'b001);
  endtask

  task automatic chk_idle(input string name);
    @(negedge clk);
    chk(name, {kif.round_key_valid_dout, kif.busy_dout, kif.done_strobe_dout}, 3'b000);
  endtask

  initial begin
    int idx;
    int cyc;
    logic rdy;

    tbl[0]  = '{4'd15, 48'hCB3D8B0E17F5};
    tbl[1]  = '{4'd14, 48'hBF918D3D3F0A};
    tbl[2]  = '{4'd13, 48'h5F43B7F2E73A};
    tbl[3]  = '{4'd12, 48'h97C5D1FABA41};
    tbl[4]  = '{4'd11, 48'h7571F59467E9};
    tbl[5]  = '{4'd10, 48'h215FD3DED386};
    tbl[6]  = '{4'd9,  48'hB1F347BA464F};
    tbl[7]  = '{4'd8,  48'hE0DBEBEDE781};
    tbl[8]  = '{4'd7,  48'hF78A3AC13BFB};
    tbl[9]  = '{4'd6,  48'hEC84B7F618BC};
    tbl[10] = '{4'd5,  48'h63A53E507B2F};
    tbl[11] = '{4'd4,  48'h7CEC07EB53A8};
    tbl[12] = '{4'd3,  48'h72ADD6DB351D};
    tbl[13] = '{4'd2,  48'h55FC8A42CF99};
    tbl[14] = '{4'd1,  48'h79AED9DBC9E5};
    tbl[15] = '{4'd0,  48'h1B02EFFC7072};

    reset                   = 1'b1;
    kif.start_strobe_din    = 1'b0;
    kif.key_din             = '0;
    kif.round_key_ready_din = 1'b0;

    // Reset and idle
    repeat (3) step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset_idle", {kif.round_key_valid_dout, kif.busy_dout, kif.done_strobe_dout,
                         kif.round_number_dout, kif.round_key_dout}, 64'd0);
      step();
    end

    // Known vector, ready held high
    do_start(main_key);
    emit_all(1'b0);
    step();
    chk_idle("done_drop");

    // Backpressure with pseudo-random ready
    do_start(main_key);
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 400) begin
      rdy = 1'($urandom_range(0, 1));
      kif.round_key_ready_din = rdy;
      @(negedge clk);
      chk("bp_key", {kif.round_key_valid_dout, kif.round_number_dout, kif.round_key_dout},
          {1'b1, tbl[idx].rnd, tbl[idx].key});
      step();
      if (rdy) idx++;
      cyc++;
    end
    chk("bp_count", 64'(idx), 64'd16);
    @(negedge clk);
    chk("bp_done", {kif.round_key_valid_dout, kif.busy_dout, kif.done_strobe_dout}, 3'b001);
    kif.round_key_ready_din = 1'b1;
    step();

    // Ignored starts at round 8 and on the final handshake, then restart one cycle later
    do_start(main_key);
    emit_all(1'b1);
    do_start(main_key);
    emit_all(1'b0);
    step();
    chk_idle("restart_idle");

    // Reset after round 10 is accepted
    do_start(main_key);
    for (int i = 0; i < 6; i++) begin
      kif.round_key_ready_din = 1'b1;
      @(negedge clk);
      chk("pre_reset", {kif.round_number_dout, kif.round_key_dout}, {tbl[i].rnd, tbl[i].key});
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_reset", {kif.round_key_valid_dout, kif.busy_dout, kif.done_strobe_dout,
                      kif.round_number_dout, kif.round_key_dout}, 64'd0);
    step();
    chk_idle("post_reset_nodone");
    step();
    do_start(main_key);
    emit_all(1'b0);
    step();

    // Parity bits must not matter
    do_start(parity_key);
    emit_all(1'b0);
    step();
    chk_idle("parity_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
